// File: rtl/lms_weight_update.sv
// LMS weight-update stage: takes mu*e*x[k] products one tap at a time, rescales them and
// accumulates them into a bank of saturating signed 8-bit weights.
module lms_weight_update #(
  parameter int TAPS  = 4,
  parameter int SHIFT = 7,
  parameter int IDXW  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic               clear,
  input  logic [15:0]        prod_in,
  input  logic               prod_valid,
  output logic               prod_req,
  output logic [IDXW-1:0]    tap_sel,
  input  logic [IDXW-1:0]    w_rd_idx,
  output logic [7:0]         w_rd_data,
  output logic               busy,
  output logic               sat,
  output logic               done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_UPD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [IDXW-1:0] LAST_TAP = IDXW'(TAPS - 1);

  logic [2:0]        state;
  logic [IDXW-1:0]   tap_cnt;
  logic              armed;
  logic signed [15:0] prod_q;
  logic signed [7:0]  weight [TAPS];

  logic signed [15:0] shifted;
  logic signed [8:0]  delta;
  logic signed [7:0]  w_cur;
  logic signed [9:0]  sum;
  logic signed [7:0]  w_new;
  logic               clamp;
  logic               unused_shift;

  assign shifted      = prod_q >>> SHIFT;
  assign delta        = shifted[8:0];
  assign unused_shift = ^shifted[15:9];
  assign w_cur        = weight[tap_cnt];
  assign sum          = {{2{w_cur[7]}}, w_cur} + {delta[8], delta};

  // Representable in 8 bits only when the top three bits of the 10-bit sum agree.
  always_comb begin
    w_new = sum[7:0];
    clamp = 1'b0;
    if (!sum[9] && (sum[8:7] != 2'b00)) begin
      w_new = 8'sh7f;
      clamp = 1'b1;
    end else if (sum[9] && (sum[8:7] != 2'b11)) begin
      w_new = -8'sd128;
      clamp = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tap_cnt <= '0;
      armed   <= 1'b0;
      prod_q  <= '0;
      for (int i = 0; i < TAPS; i++) weight[i] <= '0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          if (clear) begin
            for (int i = 0; i < TAPS; i++) weight[i] <= '0;
          end else if (start) begin
            tap_cnt <= '0;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          armed <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A valid still high from the previous tap must drop before it can qualify.
          if (!prod_valid) begin
            armed <= 1'b1;
          end else if (armed) begin
            prod_q <= prod_in;
            state  <= S_UPD;
          end
        end
        S_UPD: begin
          weight[tap_cnt] <= w_new;
          if (tap_cnt == LAST_TAP) begin
            state <= S_DONE;
          end else begin
            tap_cnt <= tap_cnt + 1'b1;
            state   <= S_REQ;
          end
        end
        S_DONE: begin
          tap_cnt <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign prod_req  = enable && (state == S_REQ);
  assign sat       = enable && (state == S_UPD) && clamp;
  assign done      = enable && (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign tap_sel   = tap_cnt;
  assign w_rd_data = weight[w_rd_idx];

endmodule
